serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that reuses one full adder, built from two `half_addar` instances plus an OR gate, across all bit positions of a WIDTH-bit operand pair. It holds a carry flip-flop between cycles and sequences the shared adder LSB-first. It produces a registered sum and carry-out with a busy/done handshake. It sits between a requesting host FSM and the half-adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `a` input WIDTH: operand A, captured on accepted start.
- `b` input WIDTH: operand B, captured on accepted start.
- `sub` input 1: present only with `SERIAL_ADD_SUB_EN`; captured on accepted start; 1 = A−B.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse, high in DONE.
- `sum` output WIDTH: registered result; held until the next result completes.
- `cout` output 1: registered final carry; held with `sum`.

## Operation
- Reset values: state = IDLE; `busy`, `done`, `cout` = 0; `sum` = 0; carry FF = 0; bit counter = 0; operand shift registers = 0.
- States and transitions:
  - IDLE: stays in IDLE until `start`=1; then → RUN.
  - RUN: counter runs 0..WIDTH−1; at count WIDTH−1 → DONE.
  - DONE: lasts one cycle; `start`=1 → RUN (back-to-back accept); else → IDLE.
- Accepted start performs all of the following in one cycle:
  - Loads `a` and `b` into the A and B shift registers.
  - Clears the counter.
  - Sets carry FF = 0.
- Per RUN cycle:
  - The full adder takes A[0], B[0] and the carry FF.
  - Its sum bit shifts into the MSB of the result shift register.
  - A and B shift right by one.
  - The carry FF takes the adder carry.
  - The counter increments.
- RUN → DONE transition: `sum` ← result register with the final bit included; `cout` ← final carry.
- `sum` and `cout` change only on that transition; they are stable at all other times.
- `start` while in RUN: ignored. Operands and state are unaffected, and there is no queueing.
- `a`, `b` and `sub` are don't-care except in the accepting cycle.
- `rst` mid-RUN: returns to IDLE next edge; all outputs go to their reset values. A pending `done` is lost.
- Arithmetic:
  - `sum` = (A + B) mod 2^WIDTH.
  - `cout` = bit WIDTH of the true sum.
  - No overflow flag.
- Counter width is `$clog2(WIDTH)` bits.

## Timing
- `start` sampled high at edge T in IDLE or DONE: `busy`=1 during cycles T+1 .. T+WIDTH.
- `done`=1 during cycle T+WIDTH+1 only, with `sum` and `cout` valid from that cycle.
- Latency start → done is WIDTH+1 cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles when `start` is held high.
- `busy` and `done` are never high in the same cycle.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - The `sub` port exists.
  - When captured `sub`=1, the B shift register loads ~`b` and the carry FF initialises to 1, giving two's-complement A−B.
  - In subtract mode, `cout`=1 means no borrow (A ≥ B unsigned).
- `SERIAL_ADD_SUB_EN` undefined:
  - No `sub` port.
  - Carry FF always initialises to 0; add only.
  - No inversion logic is synthesised.

## Test plan
- Reset then basic add, WIDTH=8: `a`=0x5A, `b`=0x33, one-cycle `start` → `busy` for 8 cycles, `done` pulse on cycle 9, `sum`=0x8D, `cout`=0.
- Carry ripple/wrap: `a`=0xFF, `b`=0x01 → `sum`=0x00, `cout`=1; then `a`=0x00, `b`=0x00 → `sum`=0x00, `cout`=0.
- Start during busy: start `a`=0x0F, `b`=0x01, then pulse `start` with `a`=0xAA, `b`=0xAA at cycle 3 → single `done`, `sum`=0x10; no second `done` within 20 cycles.
- Reset mid-operation: assert `rst` at cycle 4 of RUN → next cycle `busy`=0, `done`=0, `sum`=0x00, `cout`=0; a subsequent 0x03+0x04 yields 0x07.
- Back-to-back: `start` held high with 0x01+0x01, then 0x80+0x80 presented in the DONE cycle → `done` pulses 9 cycles apart; results 0x02/`cout`=0, then 0x00/`cout`=1.
- With `SERIAL_ADD_SUB_EN`, `sub`=1:
  - 0x10−0x01 → `sum`=0x0F, `cout`=1.
  - 0x01−0x02 → `sum`=0xFF, `cout`=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl (with helper half_addar)
//  Brief    : Bit-serial WIDTH-bit adder. One full adder (two half adders
//             plus an OR) is reused LSB-first over WIDTH RUN cycles, with a
//             carry flip-flop between cycles and a busy/done handshake.
//             Optional subtract mode is enabled by the macro
//             SERIAL_ADD_SUB_EN (adds the `sub` port, A-B in two's
//             complement, cout=1 meaning no borrow).
//  Revision : 1.0 - initial release
// ============================================================================

module half_addar (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // The A register doubles as the result register: each RUN cycle its
    // LSB feeds the adder and the new sum bit enters at the MSB, so after
    // WIDTH shifts it holds the complete result.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_init;
    logic             w_s1, w_c1, w_fa_s, w_c2, w_fa_c;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction: add the inverted subtrahend with an initial carry of one.
    assign w_b_load = sub ? ~b : b;
    assign w_c_init = sub;
`else
    assign w_b_load = b;
    assign w_c_init = 1'b0;
`endif

    // Shared full adder built from two half adders and an OR gate.
    half_addar u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(w_s1),   .c_o(w_c1));
    half_addar u_ha1 (.a_i(w_s1),   .b_i(carry_q), .s_o(w_fa_s), .c_o(w_c2));
    assign w_fa_c = w_c1 | w_c2;

    // Next-state logic: accept/load, per-bit shift, and result commit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    state_d = c_RUN;
                    a_d     = a;
                    b_d     = w_b_load;
                    carry_d = w_c_init;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_RUN: begin
                a_d     = {w_fa_s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = w_fa_c;
                cnt_d   = cnt_q + c_CW'(1);
                if (cnt_q == c_LAST_CNT) begin
                    state_d = c_DONE;
                    done_d  = 1'b1;
                    sum_d   = {w_fa_s, a_q[WIDTH-1:1]};
                    cout_d  = w_fa_c;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Brief    : Self-checking bench for serial_add_ctrl (WIDTH=8). Directed
//             scenarios plus random operations checked against an
//             arithmetic reference model. Subtract cases run only when
//             SERIAL_ADD_SUB_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub_r;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    // Last committed result, expected to be held on the outputs.
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry/no-borrow, result} from plain arithmetic.
    function automatic logic [W:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        int t;
        if (s) begin
            t = int'(x) - int'(y);
            return {(x >= y), t[W-1:0]};
        end
        t = int'(x) + int'(y);
        return t[W:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE; checks busy window, held outputs,
    // done pulse and result, then the return to IDLE.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        r     = ref_res(x, y, s);
        a     = x;
        b     = y;
        sub_r = s;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub_r = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("sum_hold", sum, exp_sum);
            chk("cout_hold", cout, exp_cout);
            step();
        end
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("sum_res", sum, r[W-1:0]);
        chk("cout_res", cout, r[W]);
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        step();
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        logic [W:0] r;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub_r = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        step();

        // Basic add and carry ripple/wrap.
        do_op(8'h5A, 8'h33, 1'b0);
        chk("basic_sum", sum, 8'h8D);
        do_op(8'hFF, 8'h01, 1'b0);
        chk("wrap_sum", sum, 8'h00);
        chk("wrap_cout", cout, 1);
        do_op(8'h00, 8'h00, 1'b0);

        // Start during busy is ignored.
        a = 8'h0F; b = 8'h01; sub_r = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == 2) begin
                a = 8'hAA; b = 8'hAA; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("ign_busy", busy, 1);
            step();
        end
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h10);
        chk("ign_cout", cout, 0);
        exp_sum = 8'h10; exp_cout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("ign_no_done", done, 0);
            chk("ign_no_busy", busy, 0);
        end

        // Reset in the middle of RUN.
        a = 8'h12; b = 8'h34; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_sum", sum, 0);
        chk("mrst_cout", cout, 0);
        exp_sum = '0; exp_cout = 1'b0;
        step();
        chk("mrst_idle_busy", busy, 0);
        chk("mrst_idle_done", done, 0);
        do_op(8'h03, 8'h04, 1'b0);
        chk("post_rst_sum", sum, 8'h07);

        // Back-to-back with start held high.
        a = 8'h01; b = 8'h01; start = 1'b1;
        step();
        for (int i = 0; i < W; i++) begin
            chk("b2b1_busy", busy, 1);
            step();
        end
        chk("b2b1_done", done, 1);
        chk("b2b1_sum", sum, 8'h02);
        chk("b2b1_cout", cout, 0);
        a = 8'h80; b = 8'h80;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("b2b2_busy", busy, 1);
            chk("b2b2_nodone", done, 0);
            step();
        end
        chk("b2b2_done", done, 1);
        chk("b2b2_sum", sum, 8'h00);
        chk("b2b2_cout", cout, 1);
        exp_sum = 8'h00; exp_cout = 1'b1;
        step();

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b1);
        chk("sub1_sum", sum, 8'h0F);
        chk("sub1_cout", cout, 1);
        do_op(8'h01, 8'h02, 1'b1);
        chk("sub2_sum", sum, 8'hFF);
        chk("sub2_cout", cout, 0);
`endif

        // Random operations against the reference model.
        for (int n = 0; n < 24; n++) begin
`ifdef SERIAL_ADD_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom));
`else
            do_op(W'($urandom), W'($urandom), 1'b0);
`endif
        end

        r = ref_res(8'hC8, 8'h64, 1'b0);
        do_op(8'hC8, 8'h64, 1'b0);
        chk("final_cout", cout, r[W]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
